// File: rtl/code_load_pkg.sv
// code_load_pkg: shared FSM state type and default instruction width for the code loader
package code_load_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
  localparam int CODE_DATA_WIDTH_DEF = 64;
endpackage

// File: rtl/code_load_if.sv
// code_load_if: loader bus bundle; ports: s0/s1 data/vld/last/rdy, abort, code_mem_wr_*, prog_vld/len/src/ack, load_err, busy
interface code_load_if #(
  parameter int AW = 9,
  parameter int DW = code_load_pkg::CODE_DATA_WIDTH_DEF
);
  logic [DW-1:0] s0_data, s1_data, code_mem_wr_data;
  logic s0_vld, s0_last, s0_rdy, s1_vld, s1_last, s1_rdy, abort;
  logic [AW-1:0] code_mem_wr_addr;
  logic code_mem_wr_en, prog_vld, prog_src, prog_ack, load_err, busy;
  logic [AW:0] prog_len;
  modport slave (
    input s0_data, s0_vld, s0_last, s1_data, s1_vld, s1_last, abort, prog_ack,
    output s0_rdy, s1_rdy, code_mem_wr_addr, code_mem_wr_data, code_mem_wr_en,
    output prog_vld, prog_len, prog_src, load_err, busy
  );
  modport master (
    output s0_data, s0_vld, s0_last, s1_data, s1_vld, s1_last, abort, prog_ack,
    input s0_rdy, s1_rdy, code_mem_wr_addr, code_mem_wr_data, code_mem_wr_en,
    input prog_vld, prog_len, prog_src, load_err, busy
  );
endinterface

// File: rtl/code_load_rr2.sv
// code_load_rr2: two-way round-robin grant; ports: clk, rst, req0_i, req1_i, upd_i (latch grant), gnt_o (winner index)
module code_load_rr2 (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  output logic gnt_o
);
  logic last_q;
  // last_q holds the most recently granted source; resetting it to 1 makes source 0 win the first tie
  assign gnt_o = (req0_i && req1_i) ? !last_q : req1_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else if (upd_i) last_q <= gnt_o;
endmodule

// File: rtl/code_load_arb.sv
// code_load_arb: arbitrates two instruction sources into code memory, one locked program at a time
// ports: clk, rst (async, active-high), bus (code_load_if.slave); define CODE_LOAD_OVF_CHECK_EN for counter overflow detection
module code_load_arb import code_load_pkg::*; #(
  parameter int CODE_ADDR_WIDTH = 9,
  parameter int CODE_DATA_WIDTH = CODE_DATA_WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  code_load_if.slave bus
);
  localparam int AW = CODE_ADDR_WIDTH;
  state_t state_q, state_d;
  logic grant_q, grant_d, rr_gnt, rr_upd, acc, acc_last, wr_en_q;
  logic prog_vld_q, prog_vld_d, prog_src_q, prog_src_d;
  logic [AW-1:0] cnt_q, cnt_d, wr_addr_q;
  logic [AW:0] prog_len_q, prog_len_d;
  logic [CODE_DATA_WIDTH-1:0] acc_data, wr_data_q;
  code_load_rr2 u_rr (
    .clk(clk), .rst(rst), .req0_i(bus.s0_vld), .req1_i(bus.s1_vld), .upd_i(rr_upd), .gnt_o(rr_gnt)
  );
  assign bus.s0_rdy = state_q == LOAD && !grant_q;
  assign bus.s1_rdy = state_q == LOAD && grant_q;
  assign acc = grant_q ? bus.s1_vld && bus.s1_rdy : bus.s0_vld && bus.s0_rdy;
  assign acc_data = grant_q ? bus.s1_data : bus.s0_data;
  assign acc_last = grant_q ? bus.s1_last : bus.s0_last;
  assign rr_upd = state_q == IDLE && !bus.abort && (bus.s0_vld || bus.s1_vld);
  assign bus.code_mem_wr_en = wr_en_q;
  assign bus.code_mem_wr_addr = wr_addr_q;
  assign bus.code_mem_wr_data = wr_data_q;
  assign bus.prog_vld = prog_vld_q;
  assign bus.prog_len = prog_len_q;
  assign bus.prog_src = prog_src_q;
  assign bus.busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    prog_vld_d = prog_vld_q;
    prog_len_d = prog_len_q;
    prog_src_d = prog_src_q;
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d = '0;
      prog_vld_d = 1'b0;
    end else case (state_q)
      IDLE: if (rr_upd) begin
        state_d = LOAD;
        grant_d = rr_gnt;
        cnt_d = '0;
      end
      LOAD: if (acc) begin
        cnt_d = cnt_q + AW'(1);
        if (acc_last) begin
          state_d = DONE;
          prog_vld_d = 1'b1;
          prog_len_d = {1'b0, cnt_q} + (AW+1)'(1);
          prog_src_d = grant_q;
        end
`ifdef CODE_LOAD_OVF_CHECK_EN
        else if (&cnt_q) state_d = ERR;
`endif
      end
      DONE: if (bus.prog_ack) begin
        state_d = IDLE;
        prog_vld_d = 1'b0;
      end
      default: ;
    endcase
  end
  // the write port is a pure one-cycle delay of acceptance, so a word taken alongside abort still lands
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      cnt_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      prog_vld_q <= 1'b0;
      prog_len_q <= '0;
      prog_src_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      wr_en_q <= acc;
      if (acc) begin
        wr_addr_q <= cnt_q;
        wr_data_q <= acc_data;
      end
      prog_vld_q <= prog_vld_d;
      prog_len_q <= prog_len_d;
      prog_src_q <= prog_src_d;
    end
`ifdef CODE_LOAD_OVF_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else if (bus.abort) err_q <= 1'b0;
    else if (state_q == LOAD && acc && !acc_last && &cnt_q) err_q <= 1'b1;
  assign bus.load_err = err_q;
`else
  assign bus.load_err = 1'b0;
`endif
endmodule

// File: tb/tb_code_load_arb.sv
// tb_code_load_arb: directed self-checking bench for code_load_arb with a 2-bit code address
module tb_code_load_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  code_load_if #(.AW(2), .DW(64)) bus ();
  code_load_arb #(.CODE_ADDR_WIDTH(2), .CODE_DATA_WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [66:0] wr();
    return {bus.code_mem_wr_en, bus.code_mem_wr_addr, bus.code_mem_wr_data};
  endfunction
  function automatic logic [4:0] prog();
    return {bus.prog_vld, bus.prog_len, bus.prog_src};
  endfunction
  function automatic logic [3:0] ctl();
    return {bus.busy, bus.s0_rdy, bus.s1_rdy, bus.load_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s0_vld = 0; bus.s0_last = 0; bus.s0_data = '0;
    bus.s1_vld = 0; bus.s1_last = 0; bus.s1_data = '0;
    bus.abort = 0; bus.prog_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) step();
    checks++;
    if ({wr(), prog(), ctl()} !== 76'd0) begin
      errors++; $display("FAIL reset_vals: got %h want 0", {wr(), prog(), ctl()});
    end
    rst = 0;
    step();
    checks++;
    if ({wr(), ctl()} !== 71'd0) begin
      errors++; $display("FAIL reset_idle: got %h want 0", {wr(), ctl()});
    end
  endtask

  task automatic test_single();
    bus.s0_vld = 1; bus.s0_data = 64'hA0; bus.s0_last = 0;
    step();
    checks++;
    if (ctl() !== 4'b1100) begin errors++; $display("FAIL single_grant: got %b want 1100", ctl()); end
    for (int i = 0; i < 3; i++) begin
      bus.s0_data = 64'hA0 + 64'(i); bus.s0_last = (i == 2);
      step();
      checks++;
      if (wr() !== {1'b1, 2'(i), 64'hA0 + 64'(i)}) begin
        errors++; $display("FAIL single_wr%0d: got %h want %h", i, wr(), {1'b1, 2'(i), 64'hA0 + 64'(i)});
      end
    end
    checks++;
    if ({prog(), ctl()} !== {5'b1_011_0, 4'b1000}) begin
      errors++; $display("FAIL single_done: got %b want 101101000", {prog(), ctl()});
    end
    bus.s0_vld = 0; bus.s0_last = 0;
    step();
    checks++;
    if ({wr() >> 66, prog()} !== 6'b0_1_011_0) begin
      errors++; $display("FAIL single_hold: got %b want 010110", {wr() >> 66, prog()});
    end
    bus.prog_ack = 1;
    step();
    bus.prog_ack = 0;
    checks++;
    if ({bus.prog_vld, ctl()} !== 5'd0) begin
      errors++; $display("FAIL single_ack: got %b want 00000", {bus.prog_vld, ctl()});
    end
  endtask

  task automatic test_tie();
    rst = 1; step(); rst = 0;
    bus.s0_vld = 1; bus.s0_last = 1; bus.s0_data = 64'hB0;
    bus.s1_vld = 1; bus.s1_last = 1; bus.s1_data = 64'hC0;
    step();
    checks++;
    if (ctl() !== 4'b1100) begin errors++; $display("FAIL tie_first: got %b want 1100", ctl()); end
    step();
    checks++;
    if ({wr(), prog(), ctl()} !== {1'b1, 2'd0, 64'hB0, 5'b1_001_0, 4'b1000}) begin
      errors++; $display("FAIL tie_done0: got %h want %h", {wr(), prog(), ctl()}, {1'b1, 2'd0, 64'hB0, 5'b1_001_0, 4'b1000});
    end
    bus.prog_ack = 1;
    step();
    bus.prog_ack = 0;
    checks++;
    if (ctl() !== 4'b0000) begin errors++; $display("FAIL tie_idle: got %b want 0000", ctl()); end
    step();
    checks++;
    if (ctl() !== 4'b1010) begin errors++; $display("FAIL tie_second: got %b want 1010", ctl()); end
    step();
    checks++;
    if ({wr(), prog()} !== {1'b1, 2'd0, 64'hC0, 5'b1_001_1}) begin
      errors++; $display("FAIL tie_done1: got %h want %h", {wr(), prog()}, {1'b1, 2'd0, 64'hC0, 5'b1_001_1});
    end
    idle_inputs();
    bus.prog_ack = 1;
    step();
    bus.prog_ack = 0;
  endtask

  task automatic test_abort();
    bus.s0_vld = 1; bus.s0_last = 0; bus.s0_data = 64'hD0;
    step();
    bus.prog_ack = 1;
    step();
    bus.prog_ack = 0;
    checks++;
    if ({wr(), ctl()} !== {1'b1, 2'd0, 64'hD0, 4'b1100}) begin
      errors++; $display("FAIL abort_ackignored: got %h want %h", {wr(), ctl()}, {1'b1, 2'd0, 64'hD0, 4'b1100});
    end
    bus.s0_data = 64'hD1;
    step();
    checks++;
    if (wr() !== {1'b1, 2'd1, 64'hD1}) begin errors++; $display("FAIL abort_w1: got %h want %h", wr(), {1'b1, 2'd1, 64'hD1}); end
    bus.s0_data = 64'hD2; bus.abort = 1;
    step();
    checks++;
    if ({wr(), bus.prog_vld, ctl()} !== {1'b1, 2'd2, 64'hD2, 1'b0, 4'b0000}) begin
      errors++; $display("FAIL abort_cycle: got %h want %h", {wr(), bus.prog_vld, ctl()}, {1'b1, 2'd2, 64'hD2, 5'b0});
    end
    bus.abort = 0; bus.s0_data = 64'hE0; bus.s0_last = 1;
    step();
    step();
    checks++;
    if ({wr(), prog()} !== {1'b1, 2'd0, 64'hE0, 5'b1_001_0}) begin
      errors++; $display("FAIL abort_restart: got %h want %h", {wr(), prog()}, {1'b1, 2'd0, 64'hE0, 5'b1_001_0});
    end
    idle_inputs();
    bus.prog_ack = 1;
    step();
    bus.prog_ack = 0;
  endtask

  task automatic test_overflow();
    bus.s0_vld = 1; bus.s0_last = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.s0_data = 64'hF0 + 64'(i);
      step();
      checks++;
      if (wr() !== {1'b1, 2'(i), 64'hF0 + 64'(i)}) begin
        errors++; $display("FAIL ovf_wr%0d: got %h want %h", i, wr(), {1'b1, 2'(i), 64'hF0 + 64'(i)});
      end
    end
    bus.s0_data = 64'hF4;
`ifdef CODE_LOAD_OVF_CHECK_EN
    checks++;
    if (ctl() !== 4'b1001) begin errors++; $display("FAIL ovf_err: got %b want 1001", ctl()); end
    step();
    checks++;
    if ({wr() >> 66, ctl()} !== 5'b0_1001) begin errors++; $display("FAIL ovf_stop: got %b want 01001", {wr() >> 66, ctl()}); end
`else
    checks++;
    if (ctl() !== 4'b1100) begin errors++; $display("FAIL ovf_noerr: got %b want 1100", ctl()); end
    step();
    checks++;
    if ({wr(), ctl()} !== {1'b1, 2'd0, 64'hF4, 4'b1100}) begin
      errors++; $display("FAIL ovf_wrap: got %h want %h", {wr(), ctl()}, {1'b1, 2'd0, 64'hF4, 4'b1100});
    end
`endif
    bus.s0_vld = 0; bus.abort = 1;
    step();
    bus.abort = 0;
    checks++;
    if (ctl() !== 4'b0000) begin errors++; $display("FAIL ovf_abort: got %b want 0000", ctl()); end
  endtask

  task automatic test_reset_mid();
    bus.s1_vld = 1; bus.s1_last = 0; bus.s1_data = 64'h77;
    step();
    step();
    #2 rst = 1;
    #1;
    checks++;
    if ({wr(), prog(), ctl()} !== 76'd0) begin
      errors++; $display("FAIL rstmid_vals: got %h want 0", {wr(), prog(), ctl()});
    end
    step();
    rst = 0;
    step();
    checks++;
    if ({wr() >> 66, ctl()} !== 5'b0_1010) begin
      errors++; $display("FAIL rstmid_nowr: got %b want 01010", {wr() >> 66, ctl()});
    end
    step();
    checks++;
    if (wr() !== {1'b1, 2'd0, 64'h77}) begin errors++; $display("FAIL rstmid_addr0: got %h want %h", wr(), {1'b1, 2'd0, 64'h77}); end
    idle_inputs();
    bus.abort = 1;
    step();
    bus.abort = 0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_abort();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/code_load_arb.md
CODE_LOAD_ARB -- requirements
Module: code_load_arb

Interface
REQ-001 Parameter CODE_ADDR_WIDTH, default 9, code memory word-address width.
REQ-002 Parameter CODE_DATA_WIDTH, default 64, instruction word width.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 s0_data  in  CODE_DATA_WIDTH  instruction word from source 0 (AXI-Lite register path).
REQ-006 s0_vld  in  1  source 0 word valid.
REQ-007 s0_last  in  1  source 0 word is the final word of its program.
REQ-008 s0_rdy  out  1  source 0 word accepted when s0_vld && s0_rdy.
REQ-009 s1_data, s1_vld, s1_last, s1_rdy  same widths and directions as source 0, for source 1 (stream loader).
REQ-010 abort  in  1  discard the program in progress.
REQ-011 code_mem_wr_addr  out  CODE_ADDR_WIDTH  code memory write address.
REQ-012 code_mem_wr_data  out  CODE_DATA_WIDTH  code memory write data.
REQ-013 code_mem_wr_en  out  1  code memory write strobe.
REQ-014 prog_vld  out  1  complete program resident in code memory.
REQ-015 prog_len  out  CODE_ADDR_WIDTH+1  instruction count of the resident program.
REQ-016 prog_src  out  1  source index that loaded the resident program.
REQ-017 prog_ack  in  1  consumer has taken the program; releases the arbiter.
REQ-018 load_err  out  1  sticky overflow flag.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, DONE, ERR.
- IDLE -> LOAD when either s*_vld is high: grant the winner, clear the word counter.
- LOAD -> DONE on an accepted word with last=1.
- DONE -> IDLE on prog_ack.
- ERR -> IDLE on abort.
REQ-021 Tie in IDLE SHALL go to the source not granted most recently; after reset, source 0 wins the first tie.
REQ-022 The grant SHALL be locked for the whole program: only the granted source's rdy may be high, and only in LOAD.
REQ-023 s*_rdy SHALL be combinational from state and grant only, never from s*_vld.
REQ-024 Each accepted word SHALL produce code_mem_wr_en=1 exactly one cycle later, with registered data and address equal to the counter value at acceptance.
REQ-025 The counter SHALL start at 0 per program and increment by 1 per accepted word.
REQ-026 On entry to DONE: prog_len SHALL equal the accepted-word count including the last word, prog_src SHALL equal the grant, and prog_vld SHALL be 1.
- prog_vld, prog_len and prog_src SHALL hold until prog_ack.
REQ-027 prog_ack outside DONE SHALL be ignored.
REQ-028 abort SHALL have priority over every other event in any state: next state IDLE, prog_vld=0, counter=0.
- A word accepted in the abort cycle SHALL still be written one cycle later.
REQ-029 A source dropping vld mid-program SHALL stall in LOAD with no timeout.

Reset
REQ-030 While rst is high: state=IDLE, counter=0, code_mem_wr_addr=0, code_mem_wr_data=0, code_mem_wr_en=0, s0_rdy=s1_rdy=0, prog_vld=0, prog_len=0, prog_src=0, load_err=0, busy=0, round-robin pointer=source 0.
REQ-031 Reset mid-LOAD SHALL discard the program; no write SHALL issue in the cycle after reset deassertion.

Configuration
REQ-032 With CODE_LOAD_OVF_CHECK_EN defined:
- accepting a non-last word at counter 2^CODE_ADDR_WIDTH-1 SHALL write that word, set load_err, and enter ERR (rdy=0).
- load_err SHALL clear only on rst or abort.
REQ-033 Without CODE_LOAD_OVF_CHECK_EN: the counter SHALL wrap to 0 silently, load_err SHALL be constant 0, and ERR SHALL be unreachable.

Structure
REQ-034 A shared package SHALL hold the FSM state enumeration and the CODE_DATA_WIDTH default constant.
REQ-035 Round-robin grant logic SHALL be the sub-module code_load_rr2 (inputs: two requests, update strobe; outputs: grant index).

Verification
REQ-036 Source 0 sends 3 words with last on the 3rd -> writes to addresses 0,1,2 with wr_en one cycle after each accept; prog_vld=1, prog_len=3, prog_src=0.
REQ-037 s0_vld and s1_vld both high in IDLE after reset -> source 0 granted and s1_rdy=0 throughout; after prog_ack with both still valid -> source 1 granted.
REQ-038 abort asserted after 2 accepted words -> IDLE next cycle, prog_vld stays 0; next program writes start at address 0.
REQ-039 CODE_ADDR_WIDTH=2, macro defined, 5 words with no last -> 4 writes (addresses 0..3), load_err=1, state ERR, rdy=0; without the macro -> 5th word written to address 0.
REQ-040 rst pulsed mid-LOAD -> all outputs at reset values, no spurious write afterward.
